// File: rtl/pe_port_adapter_pkg.sv
// Shared flit layout helpers and counter arithmetic for the PE-side router adapter.
// Field positions are derived from the per-coordinate address width.
package pe_port_adapter_pkg;

    localparam int CNT_W      = 16;
    localparam int MAX_FLIT_W = 1024;
    localparam int ADDR_X_LSB = 0;

    function automatic int addr_y_lsb(input int aw);
        return aw;
    endfunction

    function automatic int addr_z_lsb(input int aw);
        return 2 * aw;
    endfunction

    function automatic int payload_lsb(input int aw);
        return 3 * aw;
    endfunction

    // Fields arrive zero-extended; the caller truncates the result to its flit width.
    function automatic logic [MAX_FLIT_W-1:0] pack_flit(
        input logic [MAX_FLIT_W-1:0] x,
        input logic [MAX_FLIT_W-1:0] y,
        input logic [MAX_FLIT_W-1:0] z,
        input logic [MAX_FLIT_W-1:0] payload,
        input int                    aw
    );
        return (x << ADDR_X_LSB) | (y << addr_y_lsb(aw)) |
               (z << addr_z_lsb(aw)) | (payload << payload_lsb(aw));
    endfunction

    function automatic logic [CNT_W-1:0] sat_add(
        input logic [CNT_W-1:0] a,
        input logic [1:0]       b
    );
        logic [CNT_W:0] s;
        s = {1'b0, a} + {{(CNT_W-1){1'b0}}, b};
        return s[CNT_W] ? {CNT_W{1'b1}} : s[CNT_W-1:0];
    endfunction

endpackage

// File: rtl/pe_port_adapter_inj_fifo.sv
// Single-write, single-read synchronous FIFO holding flits waiting for router injection.
// Head output reads as zero while empty; push is refused when full regardless of pop.
module pe_inj_fifo #(
    parameter int WIDTH = 128,
    parameter int DEPTH = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             i_push,
    input  logic [WIDTH-1:0] i_data,
    input  logic             i_pop,
    output logic             o_full,
    output logic             o_empty,
    output logic [WIDTH-1:0] o_head
);
    localparam int AW = $clog2(DEPTH);

    logic [AW-1:0]    r_wptr;
    logic [AW-1:0]    r_rptr;
    logic [AW:0]      r_count;
    logic [WIDTH-1:0] r_mem [DEPTH];
    logic             w_push;
    logic             w_pop;

    assign o_full  = (r_count == (AW+1)'(DEPTH));
    assign o_empty = (r_count == '0);
    assign w_push  = i_push && !o_full;
    assign w_pop   = i_pop && !o_empty;
    assign o_head  = o_empty ? '0 : r_mem[r_rptr];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_wptr  <= '0;
            r_rptr  <= '0;
            r_count <= '0;
        end else begin
            if (w_push) r_wptr <= r_wptr + 1'b1;
            if (w_pop)  r_rptr <= r_rptr + 1'b1;
            r_count <= r_count + (AW+1)'(w_push) - (AW+1)'(w_pop);
        end
    end

    always_ff @(posedge clk) begin
        if (w_push) r_mem[r_wptr] <= i_data;
    end

endmodule

// File: rtl/pe_port_adapter.sv
// PE-side adapter for a Hoplite router: retries injection until accepted and buffers
// up to three ejected flits per cycle (x, y, z priority), dropping what does not fit.
module pe_port_adapter
    import pe_port_adapter_pkg::*;
#(
    parameter int FLIT_SIZE     = 128,
    parameter int ADDRESS_WIDTH = 3,
    parameter int INJ_DEPTH     = 4,
    parameter int EJ_DEPTH      = 8,
    localparam int PAYLOAD_W    = FLIT_SIZE - 3*ADDRESS_WIDTH
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     inj_valid,
    output logic                     inj_ready,
    input  logic [ADDRESS_WIDTH-1:0] inj_dst_x,
    input  logic [ADDRESS_WIDTH-1:0] inj_dst_y,
    input  logic [ADDRESS_WIDTH-1:0] inj_dst_z,
    input  logic [PAYLOAD_W-1:0]     inj_payload,
    output logic                     pe_in_valid,
    output logic [FLIT_SIZE-1:0]     pe_input,
    input  logic                     injection_success,
    input  logic [FLIT_SIZE-1:0]     x_eject,
    input  logic [FLIT_SIZE-1:0]     y_eject,
    input  logic [FLIT_SIZE-1:0]     z_eject,
    input  logic                     x_eject_valid,
    input  logic                     y_eject_valid,
    input  logic                     z_eject_valid,
    output logic                     ej_valid,
    input  logic                     ej_ready,
    output logic [FLIT_SIZE-1:0]     ej_flit,
    output logic [CNT_W-1:0]         inj_retry_cnt,
    output logic [CNT_W-1:0]         ej_drop_cnt
);
    localparam int EAW = $clog2(EJ_DEPTH);
    localparam int ECW = EAW + 1;

    logic [FLIT_SIZE-1:0] w_inj_flit;
    logic                 w_inj_full;
    logic                 w_inj_empty;
    logic [CNT_W-1:0]     r_retry;

    assign w_inj_flit = FLIT_SIZE'(pack_flit(MAX_FLIT_W'(inj_dst_x), MAX_FLIT_W'(inj_dst_y),
                                             MAX_FLIT_W'(inj_dst_z), MAX_FLIT_W'(inj_payload),
                                             ADDRESS_WIDTH));

    pe_inj_fifo #(
        .WIDTH (FLIT_SIZE),
        .DEPTH (INJ_DEPTH)
    ) u_inj_fifo (
        .clk     (clk),
        .rst     (rst),
        .i_push  (inj_valid),
        .i_data  (w_inj_flit),
        .i_pop   (injection_success),
        .o_full  (w_inj_full),
        .o_empty (w_inj_empty),
        .o_head  (pe_input)
    );

    assign inj_ready     = !w_inj_full;
    assign pe_in_valid   = !w_inj_empty;
    assign inj_retry_cnt = r_retry;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) r_retry <= '0;
        else if (pe_in_valid && !injection_success) r_retry <= sat_add(r_retry, 2'd1);
    end

    logic [FLIT_SIZE-1:0] r_ej_mem [EJ_DEPTH];
    logic [EAW-1:0]       r_ej_wptr;
    logic [EAW-1:0]       r_ej_rptr;
    logic [ECW-1:0]       r_ej_cnt;
    logic [CNT_W-1:0]     r_drop;
    logic [2:0]           w_ej_v;
    logic [FLIT_SIZE-1:0] w_ej_in [3];
    logic [ECW-1:0]       w_free;
    logic [ECW-1:0]       w_n_wr;
    logic [1:0]           w_drops;
    logic [2:0]           w_wr_en;
    logic [EAW-1:0]       w_wr_off [3];
    logic                 w_ej_pop;

    assign w_ej_v     = {z_eject_valid, y_eject_valid, x_eject_valid};
    assign w_ej_in[0] = x_eject;
    assign w_ej_in[1] = y_eject;
    assign w_ej_in[2] = z_eject;

    // Free space is judged before this cycle's pop; valid ejects claim consecutive slots in x, y, z order.
    always_comb begin
        w_free  = ECW'(EJ_DEPTH) - r_ej_cnt;
        w_n_wr  = '0;
        w_drops = '0;
        w_wr_en = '0;
        for (int i = 0; i < 3; i++) begin
            w_wr_off[i] = '0;
            if (w_ej_v[i]) begin
                if (w_n_wr < w_free) begin
                    w_wr_en[i]  = 1'b1;
                    w_wr_off[i] = w_n_wr[EAW-1:0];
                    w_n_wr      = w_n_wr + 1'b1;
                end else begin
                    w_drops = w_drops + 1'b1;
                end
            end
        end
    end

    assign ej_valid    = (r_ej_cnt != '0);
    assign ej_flit     = ej_valid ? r_ej_mem[r_ej_rptr] : '0;
    assign w_ej_pop    = ej_valid && ej_ready;
    assign ej_drop_cnt = r_drop;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_ej_wptr <= '0;
            r_ej_rptr <= '0;
            r_ej_cnt  <= '0;
            r_drop    <= '0;
        end else begin
            r_ej_wptr <= r_ej_wptr + w_n_wr[EAW-1:0];
            if (w_ej_pop) r_ej_rptr <= r_ej_rptr + 1'b1;
            r_ej_cnt  <= r_ej_cnt + w_n_wr - ECW'(w_ej_pop);
            r_drop    <= sat_add(r_drop, w_drops);
        end
    end

    always_ff @(posedge clk) begin
        for (int i = 0; i < 3; i++) begin
            if (w_wr_en[i]) r_ej_mem[r_ej_wptr + w_wr_off[i]] <= w_ej_in[i];
        end
    end

endmodule

// File: tb/tb_pe_port_adapter.sv
// Bench for pe_port_adapter: queue-based reference model compared every cycle,
// directed scenarios with literal expectations, then randomized traffic.
module tb_pe_port_adapter;
    localparam int FW = 128;
    localparam int AW = 3;
    localparam int PW = FW - 3*AW;

    logic          clk = 1'b0;
    logic          rst;
    logic          inj_valid, inj_ready;
    logic [AW-1:0] inj_dst_x, inj_dst_y, inj_dst_z;
    logic [PW-1:0] inj_payload;
    logic          pe_in_valid;
    logic [FW-1:0] pe_input;
    logic          injection_success;
    logic [FW-1:0] x_eject, y_eject, z_eject;
    logic          x_eject_valid, y_eject_valid, z_eject_valid;
    logic          ej_valid, ej_ready;
    logic [FW-1:0] ej_flit;
    logic [15:0]   inj_retry_cnt, ej_drop_cnt;

    always #5 clk = ~clk;

    pe_port_adapter dut (
        .clk(clk), .rst(rst),
        .inj_valid(inj_valid), .inj_ready(inj_ready),
        .inj_dst_x(inj_dst_x), .inj_dst_y(inj_dst_y), .inj_dst_z(inj_dst_z),
        .inj_payload(inj_payload),
        .pe_in_valid(pe_in_valid), .pe_input(pe_input),
        .injection_success(injection_success),
        .x_eject(x_eject), .y_eject(y_eject), .z_eject(z_eject),
        .x_eject_valid(x_eject_valid), .y_eject_valid(y_eject_valid), .z_eject_valid(z_eject_valid),
        .ej_valid(ej_valid), .ej_ready(ej_ready), .ej_flit(ej_flit),
        .inj_retry_cnt(inj_retry_cnt), .ej_drop_cnt(ej_drop_cnt)
    );

    int            checks = 0;
    int            failures = 0;
    logic [FW-1:0] inj_q[$];
    logic [FW-1:0] ej_q[$];
    int            m_retry, m_drop;
    bit            chk_en = 1'b0;

    function automatic logic [FW-1:0] mk(input logic [AW-1:0] x, input logic [AW-1:0] y,
                                         input logic [AW-1:0] z, input logic [PW-1:0] p);
        return {p, z, y, x};
    endfunction

    function automatic logic [FW-1:0] rnd_flit();
        return {$urandom, $urandom, $urandom, $urandom};
    endfunction

    task automatic chk(input string name, input logic [FW-1:0] act, input logic [FW-1:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h expected=%h", name, act, exp);
        end
    endtask

    task automatic model_reset();
        inj_q.delete();
        ej_q.delete();
        m_retry = 0;
        m_drop  = 0;
    endtask

    // Apply one clock edge's worth of behaviour using the inputs currently driven.
    task automatic model_step();
        int            pre_i, pre_e, free;
        logic [FW-1:0] nw[$];
        logic          v[3];
        logic [FW-1:0] f[3];
        pre_i = inj_q.size();
        if (pre_i > 0 && !injection_success && m_retry < 65535) m_retry++;
        if (pre_i > 0 && injection_success) void'(inj_q.pop_front());
        if (inj_valid && pre_i < 4) inj_q.push_back(mk(inj_dst_x, inj_dst_y, inj_dst_z, inj_payload));
        pre_e = ej_q.size();
        free  = 8 - pre_e;
        v = '{x_eject_valid, y_eject_valid, z_eject_valid};
        f = '{x_eject, y_eject, z_eject};
        for (int i = 0; i < 3; i++) begin
            if (v[i]) begin
                if (free > 0) begin
                    nw.push_back(f[i]);
                    free--;
                end else if (m_drop < 65535) begin
                    m_drop++;
                end
            end
        end
        if (pre_e > 0 && ej_ready) void'(ej_q.pop_front());
        foreach (nw[i]) ej_q.push_back(nw[i]);
    endtask

    always @(negedge clk) begin
        if (chk_en) begin
            chk("inj_ready",   FW'(inj_ready),   FW'(inj_q.size() < 4));
            chk("pe_in_valid", FW'(pe_in_valid), FW'(inj_q.size() > 0));
            chk("pe_input",    pe_input,         (inj_q.size() > 0) ? inj_q[0] : '0);
            chk("ej_valid",    FW'(ej_valid),    FW'(ej_q.size() > 0));
            chk("ej_flit",     ej_flit,          (ej_q.size() > 0) ? ej_q[0] : '0);
            chk("retry_cnt",   FW'(inj_retry_cnt), FW'(m_retry));
            chk("drop_cnt",    FW'(ej_drop_cnt),   FW'(m_drop));
        end
    end

    task automatic tick();
        @(posedge clk);
        model_step();
        @(negedge clk);
    endtask

    task automatic idle();
        inj_valid = 0; inj_dst_x = '0; inj_dst_y = '0; inj_dst_z = '0; inj_payload = '0;
        injection_success = 0; ej_ready = 0;
        x_eject = '0; y_eject = '0; z_eject = '0;
        x_eject_valid = 0; y_eject_valid = 0; z_eject_valid = 0;
    endtask

    task automatic set_inj(input logic v, input logic [AW-1:0] x, input logic [AW-1:0] y,
                           input logic [AW-1:0] z, input logic [PW-1:0] p);
        inj_valid = v; inj_dst_x = x; inj_dst_y = y; inj_dst_z = z; inj_payload = p;
    endtask

    task automatic set_ej(input logic vx, input logic vy, input logic vz,
                          input logic [FW-1:0] fx, input logic [FW-1:0] fy, input logic [FW-1:0] fz);
        x_eject_valid = vx; y_eject_valid = vy; z_eject_valid = vz;
        x_eject = fx; y_eject = fy; z_eject = fz;
    endtask

    task automatic randomize_inputs();
        set_inj($urandom_range(0, 2) != 0, AW'($urandom), AW'($urandom), AW'($urandom),
                {$urandom, $urandom, $urandom, $urandom});
        injection_success = ($urandom_range(0, 2) != 0);
        ej_ready = ($urandom_range(0, 3) != 0);
        set_ej($urandom_range(0, 1) == 1, $urandom_range(0, 1) == 1, $urandom_range(0, 1) == 1,
               rnd_flit(), rnd_flit(), rnd_flit());
    endtask

    logic [FW-1:0] fa[9];

    initial begin
        rst = 1'b1;
        idle();
        model_reset();
        repeat (2) @(negedge clk);
        chk("rst_inj_ready",   FW'(inj_ready),     FW'(1));
        chk("rst_pe_in_valid", FW'(pe_in_valid),   FW'(0));
        chk("rst_pe_input",    pe_input,           '0);
        chk("rst_ej_valid",    FW'(ej_valid),      FW'(0));
        chk("rst_ej_flit",     ej_flit,            '0);
        chk("rst_retry",       FW'(inj_retry_cnt), FW'(0));
        chk("rst_drop",        FW'(ej_drop_cnt),   FW'(0));
        rst = 1'b0;
        chk_en = 1'b1;

        // Single flit accepted on first offer.
        set_inj(1, 3'd1, 3'd1, 3'd1, 119'd1);
        injection_success = 1;
        tick();
        set_inj(0, '0, '0, '0, '0);
        chk("t1_valid", FW'(pe_in_valid), FW'(1));
        chk("t1_flit",  pe_input, {119'd1, 3'd1, 3'd1, 3'd1});
        tick();
        chk("t1_popped", FW'(pe_in_valid), FW'(0));
        chk("t1_retry",  FW'(inj_retry_cnt), FW'(0));

        // Five refusals then acceptance.
        set_inj(1, 3'd2, 3'd5, 3'd7, 119'h1234);
        injection_success = 0;
        tick();
        set_inj(0, '0, '0, '0, '0);
        for (int i = 0; i < 6; i++) begin
            chk("t2_stable", pe_input, mk(3'd2, 3'd5, 3'd7, 119'h1234));
            injection_success = (i == 5);
            tick();
        end
        chk("t2_retry", FW'(inj_retry_cnt), FW'(5));
        chk("t2_empty", FW'(pe_in_valid), FW'(0));

        // Fill the injection FIFO; a fifth offer must be ignored.
        injection_success = 0;
        for (int i = 0; i < 5; i++) begin
            set_inj(1, AW'(i), '0, '0, PW'(10 + i));
            tick();
            if (i == 3) chk("t3_full", FW'(inj_ready), FW'(0));
        end
        set_inj(0, '0, '0, '0, '0);
        injection_success = 1;
        for (int i = 0; i < 4; i++) begin
            chk("t3_order", pe_input, mk(AW'(i), '0, '0, PW'(10 + i)));
            tick();
        end
        chk("t3_no_fifth", FW'(pe_in_valid), FW'(0));
        injection_success = 0;

        // Ejection overflow with the client stalled.
        for (int i = 0; i < 9; i++) fa[i] = FW'(128'hA0 + i);
        ej_ready = 0;
        for (int c = 0; c < 3; c++) begin
            set_ej(1, 1, 1, fa[3*c], fa[3*c+1], fa[3*c+2]);
            tick();
        end
        set_ej(0, 0, 0, '0, '0, '0);
        chk("t4_drop", FW'(ej_drop_cnt), FW'(1));
        ej_ready = 1;
        for (int i = 0; i < 8; i++) begin
            chk("t4_order", ej_flit, fa[i]);
            tick();
        end
        chk("t4_drained", FW'(ej_valid), FW'(0));

        // Continuous triple ejects while the client drains one per cycle.
        for (int c = 0; c < 4; c++) begin
            set_ej(1, 1, 1, FW'(128'hB0 + 3*c), FW'(128'hB1 + 3*c), FW'(128'hB2 + 3*c));
            tick();
            if (c == 2) chk("t5_no_drop_yet", FW'(ej_drop_cnt), FW'(1));
        end
        chk("t5_drop", FW'(ej_drop_cnt), FW'(3));
        set_ej(0, 0, 0, '0, '0, '0);
        repeat (8) tick();

        // Randomized traffic.
        for (int c = 0; c < 400; c++) begin
            randomize_inputs();
            tick();
        end

        // Asynchronous reset with buffered state.
        idle();
        injection_success = 0;
        for (int i = 0; i < 3; i++) begin
            set_inj(1, AW'(i), AW'(i), AW'(i), PW'(i + 50));
            set_ej(1, 1, 1, rnd_flit(), rnd_flit(), rnd_flit());
            tick();
        end
        idle();
        tick();
        tick();
        chk_en = 1'b0;
        #2 rst = 1'b1;
        #1;
        chk("arst_pe_in_valid", FW'(pe_in_valid),   FW'(0));
        chk("arst_pe_input",    pe_input,           '0);
        chk("arst_inj_ready",   FW'(inj_ready),     FW'(1));
        chk("arst_ej_valid",    FW'(ej_valid),      FW'(0));
        chk("arst_ej_flit",     ej_flit,            '0);
        chk("arst_retry",       FW'(inj_retry_cnt), FW'(0));
        chk("arst_drop",        FW'(ej_drop_cnt),   FW'(0));
        @(negedge clk);
        rst = 1'b0;
        model_reset();
        chk_en = 1'b1;
        for (int c = 0; c < 100; c++) begin
            randomize_inputs();
            tick();
        end
        chk_en = 1'b0;

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
